ext_mem_loader: RTL

Host-side initiator for the CPU's external memory ports: it accepts commands on a valid/ready stream and turns them into single-cycle write or read strobes on the instruction-memory and data-memory external ports. It also gates the CPU `enable` input for a programmed number of cycles. It sits between the testbench or host link and the `cpu` top, so programs load, run and dump through one sequenced interface instead of raw port wiggling.

---
 rtl/ext_loader_pkg.sv | 21 ++
 rtl/loader_down_counter.sv | 27 ++
 rtl/ext_mem_loader.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ext_loader_pkg.sv
// Shared op codes, FSM states and bus widths for the external memory loader.
package ext_loader_pkg;

  localparam int unsigned ADDR_W   = 64;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned IMEM_W   = 32;

  localparam logic [1:0] OP_WR_IMEM = 2'b00;
  localparam logic [1:0] OP_WR_DMEM = 2'b01;
  localparam logic [1:0] OP_RD_DMEM = 2'b10;
  localparam logic [1:0] OP_RUN     = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_WAIT,
    ST_RUN,
    ST_RESP
  } state_e;

endpackage

// File: rtl/loader_down_counter.sv
// Loadable down counter with a zero flag; holds at zero instead of wrapping.
module loader_down_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && !zero_c) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/ext_mem_loader.sv
// Host command sequencer driving the CPU external memory ports and run enable.
module ext_mem_loader
  import ext_loader_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              enable,
  output logic [ADDR_W-1:0] addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [IMEM_W-1:0] wdata_ext,
  input  logic [IMEM_W-1:0] rdata_ext,
  output logic [ADDR_W-1:0] addr_ext_2,
  output logic              wen_ext_2,
  output logic              ren_ext_2,
  output logic [DATA_W-1:0] wdata_ext_2,
  input  logic [DATA_W-1:0] rdata_ext_2
);

  state_e state_q, state_d;

  logic              cmd_ready_d, busy_d, enable_d, rsp_valid_d;
  logic              wen_ext_d, wen_ext_2_d, ren_ext_2_d;
  logic [ADDR_W-1:0] addr_ext_d, addr_ext_2_d;
  logic [IMEM_W-1:0] wdata_ext_d;
  logic [DATA_W-1:0] wdata_ext_2_d, rsp_data_d;
  logic [CNT_W-1:0]  run_n_q, run_n_d, run_val_c, req_n_c;
  logic              run_load_c, run_dec_c, run_zero_c;
  logic              lat_load_c, lat_dec_c, lat_zero_c;
  logic              cmd_fire_c;

  // Instruction-memory reads are reserved for a future RD_IMEM op.
  logic unused_rdata_ext;
  assign unused_rdata_ext = ^rdata_ext;
  assign ren_ext          = 1'b0;

  assign cmd_fire_c = cmd_valid && cmd_ready;
  assign req_n_c    = cmd_wdata[CNT_W-1:0];
  // Loaded with N-1 so the zero flag marks the last enabled cycle.
  assign run_val_c  = req_n_c - CNT_W'(1);

  loader_down_counter #(.CNT_W(CNT_W)) u_run_cnt (
    .clk      (clk),
    .arst_n   (arst_n),
    .load     (run_load_c),
    .load_val (run_val_c),
    .dec      (run_dec_c),
    .zero_c   (run_zero_c)
  );

  loader_down_counter #(.CNT_W(CNT_W)) u_lat_cnt (
    .clk      (clk),
    .arst_n   (arst_n),
    .load     (lat_load_c),
    .load_val (CNT_W'(RD_LAT)),
    .dec      (lat_dec_c),
    .zero_c   (lat_zero_c)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state plus next value of every registered output.
  always_comb begin
    state_d       = state_q;
    enable_d      = 1'b0;
    rsp_valid_d   = 1'b0;
    wen_ext_d     = 1'b0;
    wen_ext_2_d   = 1'b0;
    ren_ext_2_d   = 1'b0;
    addr_ext_d    = addr_ext;
    wdata_ext_d   = wdata_ext;
    addr_ext_2_d  = addr_ext_2;
    wdata_ext_2_d = wdata_ext_2;
    rsp_data_d    = rsp_data;
    run_n_d       = run_n_q;
    run_load_c    = 1'b0;
    run_dec_c     = 1'b0;
    lat_load_c    = 1'b0;
    lat_dec_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire_c) begin
          case (cmd_op)
            OP_WR_IMEM: begin
              addr_ext_d  = cmd_addr;
              wdata_ext_d = cmd_wdata[IMEM_W-1:0];
              wen_ext_d   = 1'b1;
              state_d     = ST_WRITE;
            end
            OP_WR_DMEM: begin
              addr_ext_2_d  = cmd_addr;
              wdata_ext_2_d = cmd_wdata;
              wen_ext_2_d   = 1'b1;
              state_d       = ST_WRITE;
            end
            OP_RD_DMEM: begin
              addr_ext_2_d = cmd_addr;
              ren_ext_2_d  = 1'b1;
              lat_load_c   = 1'b1;
              state_d      = ST_RD_WAIT;
            end
            default: begin
              run_n_d = req_n_c;
              if (req_n_c == '0) begin
                rsp_data_d  = '0;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
              end else begin
                run_load_c = 1'b1;
                enable_d   = 1'b1;
                state_d    = ST_RUN;
              end
            end
          endcase
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_RD_WAIT: begin
        if (lat_zero_c) begin
          rsp_data_d  = rdata_ext_2;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          lat_dec_c = 1'b1;
        end
      end
      ST_RUN: begin
        if (run_zero_c) begin
          rsp_data_d  = DATA_W'(run_n_q);
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          run_dec_c = 1'b1;
          enable_d  = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
        else           rsp_valid_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = !cmd_ready_d;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      enable      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      wen_ext     <= 1'b0;
      wen_ext_2   <= 1'b0;
      ren_ext_2   <= 1'b0;
      addr_ext    <= '0;
      wdata_ext   <= '0;
      addr_ext_2  <= '0;
      wdata_ext_2 <= '0;
      run_n_q     <= '0;
    end else begin
      cmd_ready   <= cmd_ready_d;
      busy        <= busy_d;
      enable      <= enable_d;
      rsp_valid   <= rsp_valid_d;
      rsp_data    <= rsp_data_d;
      wen_ext     <= wen_ext_d;
      wen_ext_2   <= wen_ext_2_d;
      ren_ext_2   <= ren_ext_2_d;
      addr_ext    <= addr_ext_d;
      wdata_ext   <= wdata_ext_d;
      addr_ext_2  <= addr_ext_2_d;
      wdata_ext_2 <= wdata_ext_2_d;
      run_n_q     <= run_n_d;
    end
  end

endmodule
